// File: rtl/harvos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : harvos_pkg
// Description : Shared types and constants for the harvos data-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
package harvos_pkg;

    // Width of one data-memory word in bytes.
    localparam int unsigned DMEM_WORD_BYTES = 4;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_rsp_state_e;

endpackage
`default_nettype wire

// File: rtl/harvos_dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : harvos_dmem_if
// Description : Data-memory bus between the arbiter (master) and a memory
//               responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface harvos_dmem_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, rvalid, fault
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, rvalid, fault
    );

endinterface
`default_nettype wire

// File: rtl/dmem_sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sram_bank
// Description : Single-port word-wide SRAM with per-byte write enables and a
//               registered (synchronous) read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_bank
    import harvos_pkg::*;
#(
    parameter int unsigned WORDS  = 4096,
    parameter int unsigned ADDR_W = $clog2(WORDS)
) (
    input  logic                       clk,
    input  logic                       i_en,
    input  logic                       i_we,
    input  logic [DMEM_WORD_BYTES-1:0] i_be,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [31:0]                i_wdata,
    output logic [31:0]                o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_q;

    // One access per enabled cycle: byte-lane write, or word read into r_q.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the harvos data bus. Accepts one
//               request, waits WAIT_STATES cycles, then answers for exactly
//               one cycle. Range/alignment/empty-write errors are reported
//               through fault and counted in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import harvos_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    harvos_dmem_if.slave       dmem,
    output logic [15:0]        fault_cnt
);

    localparam int unsigned c_ADDR_W    = $clog2(MEM_WORDS);
    localparam logic [32:0] c_BASE_EXT  = {1'b0, BASE_ADDR};
    // Upper bound is formed in 33 bits so a bank ending at 4 GiB cannot wrap.
    localparam logic [32:0] c_LIMIT_EXT = c_BASE_EXT
                                        + 33'(MEM_WORDS) * 33'(DMEM_WORD_BYTES);
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);

    dmem_rsp_state_e r_state;
    dmem_rsp_state_e w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            w_latch;

    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic            w_we;
    logic [3:0]      w_be;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;

    logic [32:0]     w_addr_ext;
    logic            w_out_of_range;
    logic            w_misaligned;
    logic            w_empty_write;
    logic            w_fault;
    logic            w_commit;
    logic            w_sram_en;
    logic [31:0]     w_sram_q;

    logic            r_rvalid;
    logic            r_fault;
    logic            r_rd_ok;
    logic [15:0]     r_fault_cnt;

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down (or abort) in WAIT, one-cycle RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem.req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = c_WAIT_INIT;
                    w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dmem.req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request fields on accept; the bus copy is not used afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_latch) begin
            r_we    <= dmem.we;
            r_be    <= dmem.be;
            r_addr  <= dmem.addr;
            r_wdata <= dmem.wdata;
        end
    end

    // Fields of the transfer in flight: with zero wait states the SRAM access
    // shares the accept edge, so in IDLE the values being latched are used.
    always_comb begin
        w_we    = r_we;
        w_be    = r_be;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_we    = dmem.we;
            w_be    = dmem.be;
            w_addr  = dmem.addr;
            w_wdata = dmem.wdata;
        end
    end

    assign w_addr_ext     = {1'b0, w_addr};
    assign w_out_of_range = (w_addr_ext < c_BASE_EXT) || (w_addr_ext >= c_LIMIT_EXT);
    assign w_misaligned   = |w_addr[1:0];
    assign w_empty_write  = w_we && (w_be == 4'd0);
    assign w_fault        = w_out_of_range || w_misaligned || w_empty_write;

    // The edge entering RESP commits the access; reset on that edge cancels it.
    assign w_commit  = rst_n && (w_state_nxt == RESP);
    assign w_sram_en = w_commit && !w_fault;

    // Base is aligned to the bank size, so the word index is a plain slice.
    dmem_sram_bank #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (c_ADDR_W)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr[c_ADDR_W+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_sram_q)
    );

    // Registered response flags, set only for the single RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
            r_rd_ok  <= 1'b0;
        end else begin
            r_rvalid <= w_commit;
            r_fault  <= w_commit && w_fault;
            r_rd_ok  <= w_commit && !w_fault && !w_we;
        end
    end

    // Saturating count of faulted responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault_cnt <= 16'd0;
        end else if (w_commit && w_fault && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    assign dmem.rvalid = r_rvalid;
    assign dmem.fault  = r_fault;
    assign dmem.rdata  = r_rd_ok ? w_sram_q : 32'd0;
    assign fault_cnt   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder with three
//               instances (2, 3 and 0 wait states) sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sel;

    logic        m_rvalid;
    logic        m_fault;
    logic [31:0] m_rdata;
    logic [15:0] m_fcnt;
    logic [15:0] fc_w2, fc_w3, fc_w0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    harvos_dmem_if bus_w2();
    harvos_dmem_if bus_w3();
    harvos_dmem_if bus_w0();

    assign bus_w2.req = req && (sel == 2'd0);
    assign bus_w3.req = req && (sel == 2'd1);
    assign bus_w0.req = req && (sel == 2'd2);
    assign bus_w2.we = we;  assign bus_w2.be = be;  assign bus_w2.addr = addr;  assign bus_w2.wdata = wdata;
    assign bus_w3.we = we;  assign bus_w3.be = be;  assign bus_w3.addr = addr;  assign bus_w3.wdata = wdata;
    assign bus_w0.we = we;  assign bus_w0.be = be;  assign bus_w0.addr = addr;  assign bus_w0.wdata = wdata;

    dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .dmem(bus_w2), .fault_cnt(fc_w2));
    dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n), .dmem(bus_w3), .fault_cnt(fc_w3));
    dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .dmem(bus_w0), .fault_cnt(fc_w0));

    // Route the selected instance's outputs to the checker.
    always_comb begin
        m_rvalid = bus_w2.rvalid;
        m_fault  = bus_w2.fault;
        m_rdata  = bus_w2.rdata;
        m_fcnt   = fc_w2;
        case (sel)
            2'd1: begin
                m_rvalid = bus_w3.rvalid; m_fault = bus_w3.fault;
                m_rdata  = bus_w3.rdata;  m_fcnt  = fc_w3;
            end
            2'd2: begin
                m_rvalid = bus_w0.rvalid; m_fault = bus_w0.fault;
                m_rdata  = bus_w0.rdata;  m_fcnt  = fc_w0;
            end
            default: ;
        endcase
    end

    // Master must hold its fields while req stays high outside a response.
    logic        p_req = 1'b0;
    logic        p_rv  = 1'b0;
    logic        p_rst = 1'b0;
    logic [68:0] p_f   = '0;
    always @(negedge clk) begin
        if (req && p_req && !p_rv && !m_rvalid && rst_n && p_rst) begin
            assert ({we, be, addr, wdata} == p_f)
                else $error("FAIL proto_hold: fields %h changed from %h", {we, be, addr, wdata}, p_f);
        end
        p_req <= req;
        p_rv  <= m_rvalid;
        p_rst <= rst_n;
        p_f   <= {we, be, addr, wdata};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer; lat counts cycles from the req cycle to the rvalid cycle (-1 on timeout).
    task automatic xfer(input logic i_we, input logic [3:0] i_be, input logic [31:0] i_addr,
                        input logic [31:0] i_wdata, output int lat, output logic [31:0] rd,
                        output logic flt);
        @(posedge clk); #1;
        req = 1'b1; we = i_we; be = i_be; addr = i_addr; wdata = i_wdata;
        lat = -1; rd = 32'd0; flt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_rvalid) begin
                lat = k; rd = m_rdata; flt = m_fault;
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic xfer_chk(input string tag, input logic i_we, input logic [3:0] i_be,
                            input logic [31:0] i_addr, input logic [31:0] i_wdata,
                            input int exp_lat, input logic [31:0] exp_rd, input logic exp_flt);
        int          lat;
        logic [31:0] rd;
        logic        flt;
        xfer(i_we, i_be, i_addr, i_wdata, lat, rd, flt);
        chk({tag, "_lat"},   lat, exp_lat);
        chk({tag, "_rdata"}, rd,  exp_rd);
        chk({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
    endtask

    initial begin
        logic       seen;
        logic [4:0] rv;
        logic [31:0] d1, d3;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rvalid", {31'd0, m_rvalid}, 32'd0);
        chk("rst_fault",  {31'd0, m_fault},  32'd0);
        chk("rst_rdata",  m_rdata,           32'd0);
        chk("rst_fcnt",   {16'd0, m_fcnt},   32'd0);

        // Two wait states: basic write/read, byte lanes, faults.
        xfer_chk("wr10",  1'b1, 4'hF,    32'h10, 32'hDEADBEEF, 3, 32'h0,        1'b0);
        xfer_chk("rd10",  1'b0, 4'hF,    32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0);
        xfer_chk("wr20",  1'b1, 4'hF,    32'h20, 32'h11223344, 3, 32'h0,        1'b0);
        xfer_chk("wr20b", 1'b1, 4'b0010, 32'h20, 32'h0000AA00, 3, 32'h0,        1'b0);
        xfer_chk("rd20",  1'b0, 4'hF,    32'h20, 32'h0,        3, 32'h1122AA44, 1'b0);
        xfer_chk("wrFC",  1'b1, 4'hF,    32'hFC, 32'h0BADF00D, 3, 32'h0,        1'b0);
        xfer_chk("rdFC",  1'b0, 4'hF,    32'hFC, 32'h0,        3, 32'h0BADF00D, 1'b0);
        chk("fcnt0", {16'd0, m_fcnt}, 32'd0);
        xfer_chk("rd100", 1'b0, 4'hF,    32'h100, 32'h0,       3, 32'h0,        1'b1);
        xfer_chk("rd22",  1'b0, 4'hF,    32'h22,  32'h0,       3, 32'h0,        1'b1);
        xfer_chk("wrbe0", 1'b1, 4'h0,    32'h10,  32'h12345678, 3, 32'h0,       1'b1);
        chk("fcnt3", {16'd0, m_fcnt}, 32'd3);
        xfer_chk("wr12",  1'b1, 4'hF,    32'h12,  32'h77777777, 3, 32'h0,       1'b1);
        chk("fcnt4", {16'd0, m_fcnt}, 32'd4);
        xfer_chk("rd10b", 1'b0, 4'hF,    32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0);
        xfer_chk("rd20b", 1'b0, 4'hF,    32'h20, 32'h0,        3, 32'h1122AA44, 1'b0);

        // Three wait states: abort in the second WAIT cycle leaves no trace.
        sel = 2'd1;
        xfer_chk("w3_wr40", 1'b1, 4'hF, 32'h40, 32'h12345678, 4, 32'h0, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | m_rvalid;
        end
        chk("w3_abort_rvalid", {31'd0, seen}, 32'd0);
        xfer_chk("w3_rd40", 1'b0, 4'hF, 32'h40, 32'h0, 4, 32'h12345678, 1'b0);

        // Zero wait states: req held across two reads -> rvalid at N+1 and N+3.
        sel = 2'd2;
        xfer_chk("w0_wr0", 1'b1, 4'hF, 32'h0, 32'hA1A1A1A1, 1, 32'h0, 1'b0);
        xfer_chk("w0_wr4", 1'b1, 4'hF, 32'h4, 32'hB2B2B2B2, 1, 32'h0, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; wdata = 32'h0;
        @(negedge clk); rv[4] = m_rvalid;
        @(posedge clk); #1;
        @(negedge clk); rv[3] = m_rvalid; d1 = m_rdata;
        @(posedge clk); #1 addr = 32'h4;
        @(negedge clk); rv[2] = m_rvalid;
        @(posedge clk); #1;
        @(negedge clk); rv[1] = m_rvalid; d3 = m_rdata;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk); rv[0] = m_rvalid;
        chk("b2b_rvalid_pattern", {27'd0, rv}, 32'b01010);
        chk("b2b_rdata0", d1, 32'hA1A1A1A1);
        chk("b2b_rdata1", d3, 32'hB2B2B2B2);

        // Two wait states: reset on the edge that would commit a write.
        sel = 2'd0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'h55555555;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("prst_rvalid", {31'd0, m_rvalid}, 32'd0);
        chk("prst_fault",  {31'd0, m_fault},  32'd0);
        chk("prst_rdata",  m_rdata,           32'd0);
        chk("prst_fcnt",   {16'd0, m_fcnt},   32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | m_rvalid;
        end
        chk("prst_no_rvalid", {31'd0, seen}, 32'd0);
        xfer_chk("prst_rd10", 1'b0, 4'hF, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the `harvos_dmem_if` data bus: it sits below the data-memory arbiter and answers its requests. Backed by a byte-writable, word-wide synchronous SRAM bank. Features:
- Programmable wait states.
- Address-range and alignment checking, with errors reported via `fault`.
- Clean handling of requests the master withdraws before completion.

## Interface
Parameters:
- `MEM_WORDS`, 4096, SRAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_WORDS.
- `WAIT_STATES`, 1, extra cycles between accept and response; 0..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dmem`  `harvos_dmem_if.slave`  —  bus from the arbiter; signals are:
  - inputs: `req`, `we`, `be`[3:0], `addr`[31:0], `wdata`[31:0];
  - outputs: `rdata`[31:0], `rvalid`, `fault`.
- `fault_cnt`  out  16  saturating count of faulted responses.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - `req` sampled high → latch `we`/`be`/`addr`/`wdata`, load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - `req` low → abort: back to IDLE, no write, no `rvalid`.
  - Otherwise decrement the counter; when it reaches 0 the next state is RESP.
- RESP (exactly one cycle):
  - `rvalid`=1; next state is IDLE.
  - `req` during RESP belongs to the completing transfer and is ignored.
- The master holds its fields stable while `req` is high. The responder uses only the latched copy; any change is a protocol violation, flagged by a bench assertion.
- Fault check runs on the latched values. `fault`=1 if any of:
  - `addr` < BASE_ADDR, or `addr` ≥ BASE_ADDR+4*MEM_WORDS (compute in 33 bits, no wrap);
  - `addr[1:0]` != 0;
  - `we`=1 and `be`=0.
- Faulted transfer: no SRAM write; `rdata`=0; `fault_cnt` += 1, saturating at 16'hFFFF.
- Good write:
  - SRAM lanes with `be[i]`=1 are updated on the edge entering RESP.
  - `rdata`=0 in RESP.
- Good read:
  - SRAM read at word index (`addr`-BASE_ADDR)>>2 on the edge entering RESP.
  - `rdata` holds that word in RESP.
- Read-after-write to the same word in consecutive transfers returns the new data; the write has already committed.

## Timing
- Reset values: state IDLE, `rvalid`=0, `fault`=0, `rdata`=0, `fault_cnt`=0, counter 0. SRAM contents are not cleared.
- Latency: `req` first seen high in IDLE in cycle N → `rvalid` in cycle N+1+WAIT_STATES.
- `rvalid` and `fault` are registered one-cycle pulses. `fault` is 0 whenever `rvalid`=0. `rdata` is 0 outside RESP.
- Back-to-back: `req` continuously high → the next accept happens in the IDLE cycle after RESP. Throughput is one transfer per WAIT_STATES+2 cycles.
- A master yield (`req` drops for ≥1 cycle in WAIT, then rises with new fields) always aborts and restarts. The first transfer leaves no trace.
- Reset asserted in any state:
  - next cycle is IDLE;
  - a pending write is dropped, and no `rvalid` is produced for it;
  - `fault_cnt` clears.

## Structure
- `harvos_pkg`: `dmem_rsp_state_e` (IDLE/WAIT/RESP) and the `DMEM_WORD_BYTES`=4 constant.
- Sub-module `dmem_sram_bank` (MEM_WORDS x 32):
  - one port, synchronous read, per-byte write enables;
  - write-first ordering is not needed, because read and write never target the same cycle.
- The top level holds the FSM, latches, fault check and counter; roughly 150–250 lines total.

## Test plan
- WAIT_STATES=2, BASE=0:
  - write 0xDEADBEEF to 0x10 with `be`=F → `rvalid` 3 cycles after `req`, `fault`=0;
  - read of 0x10 → `rdata`=0xDEADBEEF.
- Word at 0x20 = 0x11223344; write `be`=4'b0010, `wdata`=0x0000AA00 → a read returns 0x1122AA44.
- Read at BASE+4*MEM_WORDS, at 0x22 (misaligned), and a write with `be`=0:
  - each gives `rvalid`=1, `fault`=1, `rdata`=0;
  - `fault_cnt`=3; memory unchanged.
- WAIT_STATES=3, write 0xCAFEF00D to 0x40:
  - drop `req` in the 2nd WAIT cycle → no `rvalid`;
  - a later read of 0x40 returns the old value.
- WAIT_STATES=0, `req` held high for two reads starting in cycle N → `rvalid` in cycles N+1 and N+3.
- Assert `rst_n`=0 for one cycle during WAIT of a write:
  - no `rvalid`; word unchanged;
  - all outputs 0 the cycle after reset;
  - the next request is served with nominal latency.
